dff_err_scan: RTL and testbench

//  Parametrised successor to the fixed 2x10-chain DFF error save/readout path. Drives the DUT chain

---
 rtl/dff_err_scan_pkg.sv | 33 +++
 rtl/dff_err_scan_if.sv | 22 ++
 rtl/dff_err_scan_sync_edge_det.sv | 28 ++
 rtl/dff_err_scan.sv | 166 ++++++++++++++++
 tb/tb_dff_err_scan.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/dff_err_scan_pkg.sv
// Shared encodings for the DFF error scan block: pattern modes, readout FSM states,
// and the pattern-bit selection helper.
package dff_scan_pkg;

  typedef enum logic [1:0] {
    MODE_ONE    = 2'b00,
    MODE_ZERO   = 2'b01,
    MODE_TOGGLE = 2'b10,
    MODE_EXT    = 2'b11
  } exp_mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } scan_state_e;

  function automatic logic pattern_bit(input exp_mode_e mode, input logic phase,
                                       input logic ext);
    logic b;
    case (mode)
      MODE_ONE:    b = 1'b1;
      MODE_ZERO:   b = 1'b0;
      MODE_TOGGLE: b = phase;
      default:     b = ext;
    endcase
    return b;
  endfunction

  function automatic int frame_bits(input int num_ch, input int cnt_w);
    return num_ch * cnt_w;
  endfunction

endpackage

// File: rtl/dff_err_scan_if.sv
// RPi-side readout link: save strobe and shift clock toward the scan block,
// serial data and busy flag back.
interface dff_err_scan_if;
  logic save_req;
  logic data_clk;
  logic data_out;
  logic busy;

  modport master (
    output save_req,
    output data_clk,
    input  data_out,
    input  busy
  );

  modport slave (
    input  save_req,
    input  data_clk,
    output data_out,
    output busy
  );
endinterface

// File: rtl/dff_err_scan_sync_edge_det.sv
// Two-flop synchroniser for an asynchronous level, followed by a one-cycle rising-edge pulse.
module sync_edge_det (
  input  logic clk,
  input  logic rst_b,
  input  logic d,
  output logic pulse
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      prev_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  // Pulse sits between the 2nd and 3rd edge after the input rise, so consumers act on the 3rd.
  assign pulse = sync_reg & ~prev_reg;

endmodule

// File: rtl/dff_err_scan.sv
// Pattern generator, latency-aligned chain compare, per-channel saturating error counters
// and snapshot/serial readout toward the RPi.
module dff_err_scan
  import dff_scan_pkg::*;
#(
  parameter int NUM_CH      = 20,
  parameter int CNT_W       = 16,
  parameter int LAT         = 4,
  parameter int CLR_ON_SAVE = 0
) (
  input  logic              CLK,
  input  logic              RST_B,
  input  logic              en,
  input  logic [1:0]        exp_mode,
  input  logic              ext_bit,
  input  logic              clr_cnt,
  input  logic [NUM_CH-1:0] q_in,
  dff_err_scan_if.slave     rpi,
  output logic              dut_dat,
  output logic              sat_any
);

  localparam int NBITS = frame_bits(NUM_CH, CNT_W);
  localparam int BC_W  = $clog2(NBITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              phase_reg;
  logic              dut_dat_reg;
  logic [LAT-1:0]    dly_reg;
  logic              exp_dly;
  logic [NUM_CH-1:0] q_meta_reg;
  logic [NUM_CH-1:0] q_sync_reg;
  logic [NUM_CH-1:0] err_vec;
  logic [NUM_CH-1:0] max_vec;
  logic [NBITS-1:0]  snap_flat;
  logic              sat_any_reg;
  logic              save_pulse;
  logic              clk_pulse;
  logic              save_take;

  scan_state_e       state_reg;
  logic [NBITS-1:0]  shift_reg;
  logic [BC_W-1:0]   bitcnt_reg;
  logic              data_out_reg;
  logic              busy_reg;

  // Pattern source and the expected-bit delay line (LAT covers chip round trip plus the sync stages)
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      phase_reg   <= 1'b1;
      dut_dat_reg <= 1'b1;
      dly_reg     <= '1;
    end else begin
      phase_reg   <= ~phase_reg;
      dut_dat_reg <= pattern_bit(exp_mode_e'(exp_mode), phase_reg, ext_bit);
      dly_reg     <= LAT'({dly_reg, dut_dat_reg});
    end
  end

  assign exp_dly = dly_reg[LAT-1];
  assign dut_dat = dut_dat_reg;

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      q_meta_reg <= '1;
      q_sync_reg <= '1;
    end else begin
      q_meta_reg <= q_in;
      q_sync_reg <= q_meta_reg;
    end
  end

  sync_edge_det u_save_sync (
    .clk   (CLK),
    .rst_b (RST_B),
    .d     (rpi.save_req),
    .pulse (save_pulse)
  );

  sync_edge_det u_dclk_sync (
    .clk   (CLK),
    .rst_b (RST_B),
    .d     (rpi.data_clk),
    .pulse (clk_pulse)
  );

  assign save_take = (state_reg == ST_IDLE) && save_pulse;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] cnt_reg;

    assign err_vec[gi] = en & (q_sync_reg[gi] ^ exp_dly);
    assign max_vec[gi] = (cnt_reg == CNT_MAX);
    // Channel 0 occupies the top of the frame so it leaves first.
    assign snap_flat[(NUM_CH-1-gi)*CNT_W +: CNT_W] = cnt_reg;

    always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B) begin
        cnt_reg <= '0;
      end else if (clr_cnt) begin
        cnt_reg <= '0;
      end else if ((CLR_ON_SAVE != 0) && save_take) begin
        cnt_reg <= CNT_W'(err_vec[gi]);
      end else if (err_vec[gi] && !max_vec[gi]) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      sat_any_reg <= 1'b0;
    end else if (clr_cnt) begin
      sat_any_reg <= 1'b0;
    end else if (|max_vec) begin
      sat_any_reg <= 1'b1;
    end
  end

  assign sat_any = sat_any_reg;

  // Readout FSM: the shift register doubles as the snapshot, bit NBITS-1 always on deck.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      bitcnt_reg   <= '0;
      data_out_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (save_pulse) begin
            shift_reg    <= snap_flat;
            bitcnt_reg   <= '0;
            busy_reg     <= 1'b1;
            data_out_reg <= snap_flat[NBITS-1];
            state_reg    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (clk_pulse) begin
            if (bitcnt_reg == BC_W'(NBITS - 1)) begin
              shift_reg    <= '0;
              bitcnt_reg   <= '0;
              data_out_reg <= 1'b0;
              busy_reg     <= 1'b0;
              state_reg    <= ST_IDLE;
            end else begin
              shift_reg    <= shift_reg << 1;
              bitcnt_reg   <= bitcnt_reg + BC_W'(1);
              data_out_reg <= shift_reg[NBITS-2];
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign rpi.data_out = data_out_reg;
  assign rpi.busy     = busy_reg;

endmodule

// File: tb/tb_dff_err_scan.sv
// Directed bench: two instances (snapshot keeps vs. clears live counters) share one stimulus;
// counts are observed through the serial readout frame.
module tb_dff_err_scan;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       en;
  logic [1:0] exp_mode;
  logic       ext_bit;
  logic       clr_cnt;
  logic [3:0] err_mask;
  logic [3:0] q_in;
  logic       save_req;
  logic       data_clk;
  logic       dut_dat0, dut_dat1;
  logic       sat_any0, sat_any1;
  logic [1:0] chip_pipe = 2'b11;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dff_err_scan_if rpi0 ();
  dff_err_scan_if rpi1 ();

  assign rpi0.save_req = save_req;
  assign rpi0.data_clk = data_clk;
  assign rpi1.save_req = save_req;
  assign rpi1.data_clk = data_clk;

  // Test-chip model: two cycles of external delay, plus the DUT's own two sync stages = LAT 4.
  always @(posedge clk) chip_pipe <= {chip_pipe[0], dut_dat0};
  assign q_in = {4{chip_pipe[1]}} ^ err_mask;

  dff_err_scan #(.NUM_CH(4), .CNT_W(8), .LAT(4), .CLR_ON_SAVE(0)) dut0 (
    .CLK(clk), .RST_B(rst_b), .en(en), .exp_mode(exp_mode), .ext_bit(ext_bit),
    .clr_cnt(clr_cnt), .q_in(q_in), .rpi(rpi0), .dut_dat(dut_dat0), .sat_any(sat_any0)
  );

  dff_err_scan #(.NUM_CH(4), .CNT_W(8), .LAT(4), .CLR_ON_SAVE(1)) dut1 (
    .CLK(clk), .RST_B(rst_b), .en(en), .exp_mode(exp_mode), .ext_bit(ext_bit),
    .clr_cnt(clr_cnt), .q_in(q_in), .rpi(rpi1), .dut_dat(dut_dat1), .sat_any(sat_any1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_save(input logic [3:0] inj);
    save_req = 1'b1;
    err_mask = inj;
    @(negedge clk);
    err_mask = 4'b0000;
    repeat (3) @(negedge clk);
    save_req = 1'b0;
  endtask

  task automatic read_frame(input int nbits, input int pulse_at,
                            output logic [31:0] f0, output logic [31:0] f1, output logic bp);
    f0 = '0;
    f1 = '0;
    bp = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      f0 = {f0[30:0], rpi0.data_out};
      f1 = {f1[30:0], rpi1.data_out};
      if (k == nbits - 1) bp = rpi0.busy & rpi1.busy;
      if (k == pulse_at) save_req = 1'b1;
      data_clk = 1'b1;
      repeat (4) @(negedge clk);
      save_req = 1'b0;
      data_clk = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic save_and_read(input string tag, input logic [3:0] inj, input int pulse_at,
                               input logic [31:0] exp0, input logic [31:0] exp1);
    logic [31:0] f0, f1;
    logic        bp;
    do_save(inj);
    check({tag, "_busy_on"}, 32'({rpi0.busy, rpi1.busy}), 32'h3);
    read_frame(32, pulse_at, f0, f1, bp);
    check({tag, "_frame0"}, f0, exp0);
    check({tag, "_frame1"}, f1, exp1);
    check({tag, "_busy_bit31"}, 32'(bp), 32'h1);
    check({tag, "_done"}, 32'({rpi0.busy, rpi0.data_out, rpi1.busy, rpi1.data_out}), 32'h0);
  endtask

  initial begin
    logic        a, b;
    logic [31:0] f0, f1;
    logic        bp;

    rst_b = 1'b0; en = 1'b0; exp_mode = 2'b00; ext_bit = 1'b0; clr_cnt = 1'b0;
    err_mask = 4'b0000; save_req = 1'b0; data_clk = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dut0", 32'({dut_dat0, rpi0.data_out, rpi0.busy, sat_any0}), 32'h8);
    check("reset_dut1", 32'({dut_dat1, rpi1.data_out, rpi1.busy, sat_any1}), 32'h8);
    rst_b = 1'b1;
    en    = 1'b1;
    @(negedge clk);

    // 1: toggle pattern mirrored by the chip, then mode switching
    exp_mode = 2'b10;
    @(negedge clk); a = dut_dat0;
    @(negedge clk); b = dut_dat0;
    check("toggle_alternates", 32'(a ^ b), 32'h1);
    repeat (1000) @(negedge clk);
    exp_mode = 2'b01;
    @(negedge clk);
    check("mode_zero", 32'({dut_dat0, dut_dat1}), 32'h0);
    exp_mode = 2'b11; ext_bit = 1'b1;
    @(negedge clk);
    check("mode_ext_1", 32'({dut_dat0, dut_dat1}), 32'h3);
    ext_bit = 1'b0;
    @(negedge clk);
    check("mode_ext_0", 32'({dut_dat0, dut_dat1}), 32'h0);
    exp_mode = 2'b00;
    @(negedge clk);
    check("mode_one", 32'({dut_dat0, dut_dat1}), 32'h3);
    repeat (8) @(negedge clk);
    check("t1_sat_clear", 32'({sat_any0, sat_any1}), 32'h0);
    save_and_read("t1", 4'b0000, -1, 32'h0000_0000, 32'h0000_0000);

    // 2: ten errors on channel 2
    err_mask = 4'b0100;
    repeat (10) @(negedge clk);
    err_mask = 4'b0000;
    repeat (6) @(negedge clk);
    save_and_read("t2", 4'b0000, -1, 32'h0000_0A00, 32'h0000_0A00);

    // 3: channel 1 saturates, then clr_cnt
    err_mask = 4'b0010;
    repeat (300) @(negedge clk);
    err_mask = 4'b0000;
    repeat (6) @(negedge clk);
    check("t3_sat_set", 32'({sat_any0, sat_any1}), 32'h3);
    save_and_read("t3", 4'b0000, -1, 32'h00FF_0A00, 32'h00FF_0000);
    check("t3_sat_sticky", 32'({sat_any0, sat_any1}), 32'h3);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    check("t3_sat_cleared", 32'({sat_any0, sat_any1}), 32'h0);
    save_and_read("t3clr", 4'b0000, -1, 32'h0000_0000, 32'h0000_0000);

    // 4: five errors on ch0, then one more landing on the snapshot cycle
    err_mask = 4'b0001;
    repeat (5) @(negedge clk);
    err_mask = 4'b0000;
    repeat (6) @(negedge clk);
    save_and_read("t4snap", 4'b0001, -1, 32'h0500_0000, 32'h0500_0000);
    repeat (4) @(negedge clk);
    save_and_read("t4live", 4'b0000, -1, 32'h0600_0000, 32'h0100_0000);

    // 5: save during SHIFT ignored; reset after 13 shifts aborts; fresh frame afterwards
    save_and_read("t5mid", 4'b0000, 5, 32'h0600_0000, 32'h0000_0000);
    do_save(4'b0000);
    read_frame(13, -1, f0, f1, bp);
    check("t5_partial0", f0, 32'h0000_00C0);
    check("t5_partial1", f1, 32'h0000_0000);
    rst_b = 1'b0;
    #1;
    check("t5_abort", 32'({rpi0.busy, rpi0.data_out, rpi1.busy, rpi1.data_out}), 32'h0);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    err_mask = 4'b1000;
    repeat (3) @(negedge clk);
    err_mask = 4'b0000;
    repeat (6) @(negedge clk);
    save_and_read("t5fresh", 4'b0000, -1, 32'h0000_0003, 32'h0000_0003);

    // 6: en=0 holds counters; clr_cnt beats a same-cycle error; data_clk in IDLE is inert
    en = 1'b0;
    @(negedge clk);
    err_mask = 4'b0001;
    repeat (4) @(negedge clk);
    err_mask = 4'b0000;
    repeat (4) @(negedge clk);
    en = 1'b1;
    repeat (2) @(negedge clk);
    save_and_read("t6en", 4'b0000, -1, 32'h0000_0003, 32'h0000_0000);
    err_mask = 4'b1000;
    @(negedge clk);
    err_mask = 4'b0000;
    @(negedge clk);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    repeat (6) @(negedge clk);
    save_and_read("t6clr", 4'b0000, -1, 32'h0000_0000, 32'h0000_0000);
    for (int p = 0; p < 3; p++) begin
      data_clk = 1'b1;
      repeat (4) @(negedge clk);
      data_clk = 1'b0;
      repeat (4) @(negedge clk);
      check("t6_idle_dclk", 32'({rpi0.busy, rpi0.data_out, rpi1.busy, rpi1.data_out}), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
